// File: rtl/dmem_bridge.sv
`timescale 1ns/1ps
// dmem_bridge: converts the MEM-stage combinational data request into a
// registered, held read/write handshake toward the L1 data cache. It stalls
// the pipeline until the cache responds and then returns the load data.
// A DONE state holds off re-issue while the pipeline is frozen by other
// hazards, so each MEM-stage instruction makes exactly one cache access.
// Optional feature macro: DMEM_BRIDGE_PERF_EN adds saturating performance
// counters (perf_reads, perf_writes, perf_stall_cycles).
module dmem_bridge #(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dmem_address,
    input  logic [3:0]        dmem_rmask,
    input  logic [3:0]        dmem_wmask,
    input  logic [31:0]       dmem_wdata,
    input  logic              mem_advance,
    output logic [31:0]       dmem_rdata,
    output logic              dmem_stall,
    output logic [31:0]       cache_address,
    output logic              cache_read,
    output logic              cache_write,
    output logic [3:0]        cache_byte_enable,
    output logic [31:0]       cache_wdata,
    input  logic [31:0]       cache_rdata,
    input  logic              cache_resp
`ifdef DMEM_BRIDGE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_reads,
    output logic [PERF_W-1:0] perf_writes,
    output logic [PERF_W-1:0] perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        req;
    logic        is_write_req;
    logic        read_reg;
    logic        write_reg;
    logic [31:0] address_reg;
    logic [3:0]  byte_enable_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;

    // The cache works on whole words; byte placement is carried by the mask.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^dmem_address[1:0];

    // Parameter sanity check at elaboration time.
    if (PERF_W < 1) begin : g_perf_w_check
        $error("PERF_W must be at least 1");
    end

    // A write mask wins over a read mask when both are (illegally) set.
    assign req          = (dmem_rmask != 4'b0000) || (dmem_wmask != 4'b0000);
    assign is_write_req = (dmem_wmask != 4'b0000);

    assign cache_address     = address_reg;
    assign cache_read        = read_reg;
    assign cache_write       = write_reg;
    assign cache_byte_enable = byte_enable_reg;
    assign cache_wdata       = wdata_reg;
    assign dmem_rdata        = rdata_reg;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and stall output; stall is qualified by rst so a
    // request seen during reset does not freeze the pipeline.
    always_comb begin
        state_next = state_reg;
        dmem_stall = 1'b0;
        case (state_reg)
            IDLE: begin
                dmem_stall = req & rst;
                if (req) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                dmem_stall = 1'b1;
                if (cache_resp) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (mem_advance) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture on issue, strobe drop and load-data capture on response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_reg        <= 1'b0;
            write_reg       <= 1'b0;
            address_reg     <= 32'h0;
            byte_enable_reg <= 4'h0;
            wdata_reg       <= 32'h0;
            rdata_reg       <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        address_reg <= {dmem_address[31:2], 2'b00};
                        wdata_reg   <= dmem_wdata;
                        if (is_write_req) begin
                            write_reg       <= 1'b1;
                            byte_enable_reg <= dmem_wmask;
                        end else begin
                            read_reg        <= 1'b1;
                            byte_enable_reg <= dmem_rmask;
                        end
                    end
                end
                BUSY: begin
                    if (cache_resp) begin
                        read_reg  <= 1'b0;
                        write_reg <= 1'b0;
                        if (read_reg) begin
                            rdata_reg <= cache_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DMEM_BRIDGE_PERF_EN
    logic [PERF_W-1:0] perf_reads_reg;
    logic [PERF_W-1:0] perf_writes_reg;
    logic [PERF_W-1:0] perf_stall_reg;
    logic              issue;

    assign issue             = (state_reg == IDLE) && req;
    assign perf_reads        = perf_reads_reg;
    assign perf_writes       = perf_writes_reg;
    assign perf_stall_cycles = perf_stall_reg;

    // Saturating event counters: issues by kind and stalled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_reads_reg  <= '0;
            perf_writes_reg <= '0;
            perf_stall_reg  <= '0;
        end else begin
            if (issue && !is_write_req && (perf_reads_reg != '1)) begin
                perf_reads_reg <= perf_reads_reg + 1'b1;
            end
            if (issue && is_write_req && (perf_writes_reg != '1)) begin
                perf_writes_reg <= perf_writes_reg + 1'b1;
            end
            if (dmem_stall && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for dmem_bridge: directed cases followed by randomized
// transactions, all checked against a transaction-level reference model.
module tb_dmem_bridge;

    localparam int PERF_W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dmem_address = 32'h0;
    logic [3:0]  dmem_rmask = 4'h0;
    logic [3:0]  dmem_wmask = 4'h0;
    logic [31:0] dmem_wdata = 32'h0;
    logic        mem_advance = 1'b0;
    logic [31:0] cache_rdata = 32'h0;
    logic        cache_resp = 1'b0;

    wire  [31:0] dmem_rdata;
    wire         dmem_stall;
    wire  [31:0] cache_address;
    wire         cache_read;
    wire         cache_write;
    wire  [3:0]  cache_byte_enable;
    wire  [31:0] cache_wdata;
`ifdef DMEM_BRIDGE_PERF_EN
    wire  [PERF_W-1:0] perf_reads;
    wire  [PERF_W-1:0] perf_writes;
    wire  [PERF_W-1:0] perf_stall_cycles;
`endif

    dmem_bridge #(.PERF_W(PERF_W)) dut (
        .clk               (clk),
        .rst               (rst_n),
        .dmem_address      (dmem_address),
        .dmem_rmask        (dmem_rmask),
        .dmem_wmask        (dmem_wmask),
        .dmem_wdata        (dmem_wdata),
        .mem_advance       (mem_advance),
        .dmem_rdata        (dmem_rdata),
        .dmem_stall        (dmem_stall),
        .cache_address     (cache_address),
        .cache_read        (cache_read),
        .cache_write       (cache_write),
        .cache_byte_enable (cache_byte_enable),
        .cache_wdata       (cache_wdata),
        .cache_rdata       (cache_rdata),
        .cache_resp        (cache_resp)
`ifdef DMEM_BRIDGE_PERF_EN
        ,
        .perf_reads        (perf_reads),
        .perf_writes       (perf_writes),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata = 32'h0;
    int          exp_reads = 0;
    int          exp_writes = 0;
    int          exp_stall = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_perf();
`ifdef DMEM_BRIDGE_PERF_EN
        check_eq("perf_reads", perf_reads, exp_reads);
        check_eq("perf_writes", perf_writes, exp_writes);
        check_eq("perf_stall_cycles", perf_stall_cycles, exp_stall);
`endif
    endtask

    // Idle cycles with no request; stray responses and advances must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            dmem_rmask  = 4'h0;
            dmem_wmask  = 4'h0;
            cache_resp  = 1'($urandom_range(0, 1));
            cache_rdata = $urandom;
            mem_advance = 1'($urandom_range(0, 1));
            #1;
            check_eq("idle_stall", dmem_stall, 0);
            check_eq("idle_read", cache_read, 0);
            check_eq("idle_write", cache_write, 0);
            check_eq("idle_rdata", dmem_rdata, exp_rdata);
            @(negedge clk);
        end
        cache_resp = 1'b0;
    endtask

    // One MEM-stage access: called just after a negedge with the bridge idle.
    // lat = BUSY cycles until resp, freeze = DONE cycles with mem_advance=0.
    task automatic do_access(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                             input logic [31:0] wd, input int lat, input int freeze,
                             input logic [31:0] rd);
        logic        is_wr;
        logic [3:0]  be;
        logic [31:0] waddr;
        is_wr = (wm != 4'h0);
        be    = is_wr ? wm : rm;
        waddr = addr & 32'hFFFF_FFFC;
        dmem_address = addr;
        dmem_rmask   = rm;
        dmem_wmask   = wm;
        dmem_wdata   = wd;
        cache_resp   = 1'b0;
        mem_advance  = 1'($urandom_range(0, 1));
        #1;
        check_eq("req_stall", dmem_stall, 1);
        check_eq("req_read_pre", cache_read, 0);
        check_eq("req_write_pre", cache_write, 0);
        @(negedge clk);
        for (int i = 1; i <= lat; i++) begin
            check_eq("busy_read", cache_read, !is_wr);
            check_eq("busy_write", cache_write, is_wr);
            check_eq("busy_addr", cache_address, waddr);
            check_eq("busy_be", cache_byte_enable, be);
            check_eq("busy_wdata", cache_wdata, wd);
            check_eq("busy_rdata_hold", dmem_rdata, exp_rdata);
            cache_resp  = (i == lat);
            cache_rdata = (i == lat) ? rd : $urandom;
            mem_advance = 1'($urandom_range(0, 1));
            #1;
            check_eq("busy_stall", dmem_stall, 1);
            @(negedge clk);
        end
        cache_resp = 1'b0;
        if (!is_wr) exp_rdata = rd;
        exp_stall += lat + 1;
        if (is_wr) exp_writes++; else exp_reads++;
        for (int j = 0; j <= freeze; j++) begin
            mem_advance = (j == freeze);
            #1;
            check_eq("done_stall", dmem_stall, 0);
            check_eq("done_read", cache_read, 0);
            check_eq("done_write", cache_write, 0);
            check_eq("done_rdata", dmem_rdata, exp_rdata);
            @(negedge clk);
        end
        $display("txn %s addr=%08h be=%b lat=%0d freeze=%0d rdata=%08h",
                 is_wr ? "WR" : "RD", addr, be, lat, freeze, exp_rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a request present to confirm stall is qualified.
        dmem_rmask = 4'hF;
        @(negedge clk);
        #1;
        check_eq("rst_stall", dmem_stall, 0);
        check_eq("rst_read", cache_read, 0);
        check_eq("rst_write", cache_write, 0);
        check_eq("rst_addr", cache_address, 0);
        check_eq("rst_be", cache_byte_enable, 0);
        check_eq("rst_wdata", cache_wdata, 0);
        check_eq("rst_rdata", dmem_rdata, 0);
        dmem_rmask = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Load, store, frozen pipeline, illegal masks, back-to-back.
        do_access(32'h1000_0006, 4'hF, 4'h0, 32'h0, 3, 0, 32'hDEAD_BEEF);
        do_access(32'h2000_0002, 4'h0, 4'h4, 32'h00AB_0000, 1, 0, 32'h1234_5678);
        do_access(32'h3000_0010, 4'h3, 4'h0, 32'h0, 2, 5, 32'hCAFE_F00D);
        do_access(32'h4000_0001, 4'hF, 4'h3, 32'h0000_5A5A, 2, 1, 32'h0BAD_0BAD);
        do_access(32'h5000_0000, 4'h1, 4'h0, 32'h0, 1, 0, 32'h0000_00C3);
        idle_cycles(1);

        // Reset asserted in the second BUSY cycle.
        dmem_address = 32'h6000_0008;
        dmem_rmask   = 4'hF;
        dmem_wmask   = 4'h0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rstmid_read_before", cache_read, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_read", cache_read, 0);
        check_eq("rstmid_write", cache_write, 0);
        check_eq("rstmid_stall", dmem_stall, 0);
        check_eq("rstmid_addr", cache_address, 0);
        check_eq("rstmid_rdata", dmem_rdata, 0);
        exp_rdata  = 32'h0;
        exp_reads  = 0;
        exp_writes = 0;
        exp_stall  = 0;
        @(negedge clk);
        rst_n       = 1'b1;
        dmem_rmask  = 4'h0;
        cache_resp  = 1'b1;
        cache_rdata = 32'hFFFF_FFFF;
        #1;
        check_eq("rstrel_stall", dmem_stall, 0);
        @(negedge clk);
        cache_resp = 1'b0;
        #1;
        check_eq("rstrel_read", cache_read, 0);
        check_eq("rstrel_rdata", dmem_rdata, 0);
        @(negedge clk);

        // Counter scenario: two loads and a store, one BUSY cycle each.
        do_access(32'h7000_0000, 4'hF, 4'h0, 32'h0, 1, 0, 32'h1111_1111);
        do_access(32'h7000_0004, 4'hC, 4'h0, 32'h0, 1, 0, 32'h2222_2222);
        do_access(32'h7000_0008, 4'h0, 4'h1, 32'h0000_0033, 1, 0, 32'h3333_3333);
        check_perf();

        // Randomized transactions.
        for (int t = 0; t < 150; t++) begin
            logic [3:0] rm;
            logic [3:0] wm;
            int         kind;
            idle_cycles($urandom_range(0, 2));
            kind = $urandom_range(0, 9);
            rm   = 4'h0;
            wm   = 4'h0;
            if (kind < 5) begin
                rm = 4'($urandom_range(1, 15));
            end else if (kind < 9) begin
                wm = 4'($urandom_range(1, 15));
            end else begin
                rm = 4'($urandom_range(1, 15));
                wm = 4'($urandom_range(1, 15));
            end
            do_access($urandom, rm, wm, $urandom, $urandom_range(1, 4),
                      $urandom_range(0, 3), $urandom);
        end
        check_perf();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits between the pipelined datapath's MEM-stage data port and the L1 data cache.
- Turns the datapath's combinational request (address plus read/write byte masks) into a registered, held read/write handshake toward the cache.
- Stalls the pipeline until the cache responds, then returns load data.
- Guarantees exactly one cache transaction per MEM-stage instruction, even when the pipeline is frozen by other hazards.

Parameters:
- PERF_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- dmem_address  in  32  byte address from the datapath MEM stage.
- dmem_rmask  in  4  read byte mask; nonzero means load.
- dmem_wmask  in  4  write byte mask; nonzero means store.
- dmem_wdata  in  32  lane-aligned store data.
- mem_advance  in  1  pipeline loads MEM/WB this cycle (the hazard control's load_mem_wb).
- dmem_rdata  out  32  load data to MEM/WB.
- dmem_stall  out  1  to hazard control; freezes the pipeline.
- cache_address  out  32  word-aligned address: {addr[31:2], 2'b00}.
- cache_read  out  1  read strobe, held until cache_resp.
- cache_write  out  1  write strobe, held until cache_resp.
- cache_byte_enable  out  4  mask of the issued request.
- cache_wdata  out  32  registered store data.
- cache_rdata  in  32  read data, valid with cache_resp.
- cache_resp  in  1  one-cycle completion pulse.

Behaviour:
- **States:** IDLE, BUSY, DONE.
- **Reset (rst=0, async):**
  - State goes to IDLE.
  - cache_read, cache_write = 0; cache_address, cache_byte_enable, cache_wdata, dmem_rdata = 0.
  - dmem_stall = 0, since the request condition is qualified by rst.
  - Reset in BUSY drops the strobes immediately; a cache_resp arriving after release is ignored.
- **Request detect:** req = (dmem_rmask != 0) | (dmem_wmask != 0).
  - Both masks nonzero is illegal; the write takes priority and the read mask is ignored.
- **IDLE, req=1:**
  - Latch the word-aligned address, the active mask and wdata.
  - Set cache_write if wmask!=0, else cache_read.
  - Go to BUSY.
- **IDLE, req=0:** stay; cache_resp is ignored.
- **BUSY:**
  - Strobes, address, enable and wdata are held constant.
  - On cache_resp: drop the strobes the same edge; for a read, dmem_rdata <= cache_rdata (writes leave dmem_rdata unchanged); go to DONE.
- **DONE:**
  - No strobe asserted.
  - mem_advance=1: return to IDLE.
  - mem_advance=0: stay in DONE. The instruction is still in MEM, so it must not be re-issued.
  - dmem_rdata is held throughout DONE.
- **dmem_stall (combinational):** (IDLE & req & rst) | BUSY; 0 in DONE.
- **Latency:**
  - Request visible in cycle N; strobe asserted from N+1.
  - cache_resp in cycle M ≥ N+1 gives DONE in M+1, when stall drops and MEM/WB loads dmem_rdata.
  - Minimum stall is 2 cycles (resp in N+1).
- **Back-to-back accesses:** a new req in the cycle after DONE→IDLE is detected normally; there is no idle gap beyond that state transition.
- Sub-word lane selection and sign extension stay in the datapath; the bridge passes masks and data through unchanged.

Optional Feature:
- Macro: DMEM_BRIDGE_PERF_EN.
- **Defined:** adds outputs perf_reads, perf_writes, perf_stall_cycles, each PERF_W bits.
  - perf_reads / perf_writes increment on each IDLE→BUSY transition of that kind.
  - perf_stall_cycles increments every cycle dmem_stall=1.
  - All counters saturate at all-ones and are cleared by rst.
- **Undefined:** the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- **Load:** lw at 0x1000_0006 with rmask=1111; cache resp on the 3rd BUSY cycle with rdata=0xDEAD_BEEF.
  - cache_address=0x1000_0004, cache_read=1 for 3 cycles.
  - dmem_stall high 4 cycles; dmem_rdata=0xDEADBEEF in DONE.
- **Store:** sb with wmask=0100, wdata=0x00AB_0000; resp after 1 cycle.
  - cache_write=1 with cache_byte_enable=0100 and cache_wdata=0x00AB0000 for 1 cycle; cache_read=0; dmem_rdata unchanged.
- **Frozen pipeline:** resp arrives with mem_advance=0 for 5 cycles while rmask stays nonzero.
  - State remains DONE, no second cache_read, dmem_stall=0.
  - Return to IDLE on the first mem_advance=1.
- **Illegal masks:** rmask=1111 and wmask=0011 together.
  - cache_write=1, enable=0011, cache_read never asserted.
- **Reset mid-operation:** rst=0 asserted in the 2nd BUSY cycle.
  - Strobes go to 0 asynchronously before the next edge.
  - After release with req=0, a stray cache_resp causes no state change.
- **Counters (DMEM_BRIDGE_PERF_EN):** 2 loads plus 1 store, each resp after 1 BUSY cycle.
  - perf_reads=2, perf_writes=1, perf_stall_cycles=6.
